// File: rtl/xpu_tx_queue_sched.sv
// TX queue scheduler: picks the next queue for a channel-access attempt and
// sequences backoff request, PHY TX start and try completion.
module xpu_tx_queue_sched #(
  parameter int NUM_QUEUE   = 4,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic [NUM_QUEUE-1:0]   queue_req,
  input  logic [NUM_QUEUE-1:0]   slice_en,
  input  logic                   high_trigger,
  input  logic [1:0]             hp_queue_idx,
  input  logic                   ack_tx_flag,
  input  logic                   ch_idle_final,
  input  logic                   backoff_done,
  input  logic                   tx_try_complete,
  input  logic [TIMER_WIDTH-1:0] timeout_top,
  output logic                   backoff_start,
  output logic                   phy_tx_start,
  output logic [1:0]             tx_queue_idx,
  output logic                   tx_queue_idx_valid,
  output logic                   timeout_err,
  output logic [2:0]             sched_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    BACKOFF  = 3'd2,
    TX_START = 3'd3,
    TX_WAIT  = 3'd4,
    COMPLETE = 3'd5
  } state_t;

  state_t                 state;
  logic [1:0]             last_grant;
  logic [1:0]             rr_pick;
  logic [1:0]             cand;
  logic                   rr_found;
  logic [1:0]             pick;
  logic [NUM_QUEUE-1:0]   eligible;
  logic                   bo_pend;
  logic                   bo_go;
  logic [TIMER_WIDTH-1:0] watchdog;
  logic [TIMER_WIDTH-1:0] wd_inc;
  logic                   wd_expire;

  assign eligible    = queue_req & slice_en;
  assign wd_inc      = watchdog + TIMER_WIDTH'(1);
  assign wd_expire   = (state == TX_WAIT) && (timeout_top != '0) && (wd_inc == timeout_top);
  // A completing try in the expiry cycle suppresses the watchdog error.
  assign timeout_err = wd_expire && !tx_try_complete;
  assign bo_go       = (backoff_done || bo_pend) && ch_idle_final && !ack_tx_flag;
  assign sched_state = state;

  always_comb begin
    rr_pick  = last_grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= unsigned'(NUM_QUEUE); i++) begin
      cand = last_grant + 2'(i);
      if (!rr_found && eligible[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
    pick = (high_trigger && eligible[hp_queue_idx]) ? hp_queue_idx : rr_pick;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state              <= IDLE;
      last_grant         <= 2'd3;
      tx_queue_idx       <= '0;
      tx_queue_idx_valid <= 1'b0;
      backoff_start      <= 1'b0;
      phy_tx_start       <= 1'b0;
      bo_pend            <= 1'b0;
      watchdog           <= '0;
    end else begin
      backoff_start <= 1'b0;
      phy_tx_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (eligible != '0 && !ack_tx_flag) state <= SELECT;
        end
        SELECT: begin
          if (eligible == '0) begin
            state <= IDLE;
          end else begin
            tx_queue_idx       <= pick;
            tx_queue_idx_valid <= 1'b1;
            backoff_start      <= 1'b1;
            bo_pend            <= 1'b0;
            state              <= BACKOFF;
          end
        end
        BACKOFF: begin
          // Losing the slice aborts even if backoff finishes this cycle.
          if (!slice_en[tx_queue_idx]) begin
            tx_queue_idx_valid <= 1'b0;
            bo_pend            <= 1'b0;
            state              <= IDLE;
          end else if (bo_go) begin
            phy_tx_start <= 1'b1;
            bo_pend      <= 1'b0;
            state        <= TX_START;
          end else if (backoff_done) begin
            bo_pend <= 1'b1;
          end
        end
        TX_START: begin
          watchdog <= '0;
          state    <= TX_WAIT;
        end
        TX_WAIT: begin
          watchdog <= wd_inc;
          if (tx_try_complete || wd_expire) state <= COMPLETE;
        end
        COMPLETE: begin
          last_grant         <= tx_queue_idx;
          tx_queue_idx_valid <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpu_tx_queue_sched.sv
// Randomized self-checking bench for xpu_tx_queue_sched against a
// transaction-level model of grant selection and attempt timing.
module tb_xpu_tx_queue_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  queue_req;
  logic [3:0]  slice_en;
  logic        high_trigger;
  logic [1:0]  hp_queue_idx;
  logic        ack_tx_flag;
  logic        ch_idle_final;
  logic        backoff_done;
  logic        tx_try_complete;
  logic [15:0] timeout_top;
  logic        backoff_start;
  logic        phy_tx_start;
  logic [1:0]  tx_queue_idx;
  logic        tx_queue_idx_valid;
  logic        timeout_err;
  logic [2:0]  sched_state;

  int total = 0;
  int bad   = 0;
  int last_grant = 3;

  xpu_tx_queue_sched #(.NUM_QUEUE(4), .TIMER_WIDTH(16)) dut (
    .s00_axi_aclk       (clk),
    .s00_axi_aresetn    (rst_n),
    .queue_req          (queue_req),
    .slice_en           (slice_en),
    .high_trigger       (high_trigger),
    .hp_queue_idx       (hp_queue_idx),
    .ack_tx_flag        (ack_tx_flag),
    .ch_idle_final      (ch_idle_final),
    .backoff_done       (backoff_done),
    .tx_try_complete    (tx_try_complete),
    .timeout_top        (timeout_top),
    .backoff_start      (backoff_start),
    .phy_tx_start       (phy_tx_start),
    .tx_queue_idx       (tx_queue_idx),
    .tx_queue_idx_valid (tx_queue_idx_valid),
    .timeout_err        (timeout_err),
    .sched_state        (sched_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [3:0] el, input logic ht,
                                   input logic [1:0] hp, input int lg);
    if (ht && el[hp]) return int'(hp);
    for (int i = 1; i <= 4; i++)
      if (el[(lg + i) % 4]) return (lg + i) % 4;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(sched_state), 0);
    chk({tag, "_valid"}, 32'(tx_queue_idx_valid), 0);
    chk({tag, "_idx"}, 32'(tx_queue_idx), 0);
    chk({tag, "_bstart"}, 32'(backoff_start), 0);
    chk({tag, "_phy"}, 32'(phy_tx_start), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  // mode: 0 = complete on TX_WAIT cycle k, 1 = watchdog expiry,
  //       2 = slice abort during backoff, 3 = async reset on TX_WAIT cycle k
  task automatic run_try(input logic [3:0] req, input logic [3:0] slc, input logic ht,
                         input logic [1:0] hp, input int bo_wait, input int defer_len,
                         input logic defer_by_ack, input int mode, input int tmo, input int k);
    int g;
    g = exp_grant(req & slc, ht, hp, last_grant);
    queue_req = req; slice_en = slc; high_trigger = ht; hp_queue_idx = hp;
    timeout_top = 16'(tmo); ch_idle_final = 1'b1; ack_tx_flag = 1'b0;
    @(negedge clk);
    chk("sel_state", 32'(sched_state), 1);
    chk("sel_bstart", 32'(backoff_start), 0);
    @(negedge clk);
    chk("bo_state", 32'(sched_state), 2);
    chk("bo_start", 32'(backoff_start), 1);
    chk("grant", 32'(tx_queue_idx), 32'(g));
    chk("grant_valid", 32'(tx_queue_idx_valid), 1);
    queue_req = '0; high_trigger = 1'b0;
    for (int i = 0; i < bo_wait; i++) begin
      tx_try_complete = 1'($urandom);
      @(negedge clk);
      chk("bo_wait_state", 32'(sched_state), 2);
      chk("bo_start_pulse", 32'(backoff_start), 0);
      chk("bo_wait_phy", 32'(phy_tx_start), 0);
    end
    tx_try_complete = 1'b0;
    if (mode == 2) begin
      slice_en = slc & ~(4'b0001 << g);
      backoff_done = 1'($urandom);
      @(negedge clk);
      chk("abort_state", 32'(sched_state), 0);
      chk("abort_valid", 32'(tx_queue_idx_valid), 0);
      chk("abort_phy", 32'(phy_tx_start), 0);
      backoff_done = 1'b0; slice_en = slc;
      return;
    end
    backoff_done = 1'b1;
    if (defer_len > 0) begin
      if (defer_by_ack) ack_tx_flag = 1'b1;
      else ch_idle_final = 1'b0;
    end
    @(negedge clk);
    backoff_done = 1'b0;
    if (defer_len > 0) begin
      chk("defer_phy", 32'(phy_tx_start), 0);
      chk("defer_state", 32'(sched_state), 2);
      for (int i = 1; i < defer_len; i++) begin
        @(negedge clk);
        chk("defer_phy", 32'(phy_tx_start), 0);
        chk("defer_state", 32'(sched_state), 2);
      end
      ack_tx_flag = 1'b0; ch_idle_final = 1'b1;
      @(negedge clk);
    end
    chk("phy_start", 32'(phy_tx_start), 1);
    chk("txs_state", 32'(sched_state), 3);
    if (mode == 3) begin
      for (int j = 1; j <= k; j++) begin
        @(negedge clk);
        chk("wait_state", 32'(sched_state), 4);
      end
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      last_grant = 3;
      return;
    end
    if (mode == 1) begin
      for (int j = 1; j <= tmo; j++) begin
        @(negedge clk);
        chk("wait_state", 32'(sched_state), 4);
        chk("tmo_err", 32'(timeout_err), 32'(j == tmo));
      end
    end else begin
      for (int j = 1; j <= k; j++) begin
        @(negedge clk);
        if (j == k) tx_try_complete = 1'b1;
        #1;
        chk("wait_state", 32'(sched_state), 4);
        chk("wait_tmo", 32'(timeout_err), 0);
        chk("wait_phy", 32'(phy_tx_start), 0);
      end
    end
    @(negedge clk);
    tx_try_complete = 1'b0;
    chk("cmpl_state", 32'(sched_state), 5);
    chk("cmpl_tmo", 32'(timeout_err), 0);
    @(negedge clk);
    chk("end_state", 32'(sched_state), 0);
    chk("end_valid", 32'(tx_queue_idx_valid), 0);
    chk("end_idx", 32'(tx_queue_idx), 32'(g));
    last_grant = g;
  endtask

  initial begin
    rst_n = 1'b0; queue_req = '0; slice_en = '0; high_trigger = 1'b0; hp_queue_idx = '0;
    ack_tx_flag = 1'b0; ch_idle_final = 1'b1; backoff_done = 1'b0; tx_try_complete = 1'b0;
    timeout_top = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", 32'(sched_state), 0);

    // first request after reset, then the follow-on grant
    run_try(4'b0110, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 3);
    run_try(4'b0110, 4'hF, 1'b0, 2'd0, 1, 0, 1'b0, 0, 0, 2);
    // round robin over all four queues, starting after queue 3
    run_try(4'b1000, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    for (int n = 0; n < 8; n++)
      run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    // priority queue overrides round robin
    run_try(4'b0001, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    run_try(4'hF, 4'hF, 1'b1, 2'd3, 0, 0, 1'b0, 0, 0, 1);
    // deferral until channel idle 5 cycles later
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 2, 5, 1'b0, 0, 0, 2);
    // slice abort leaves last grant untouched
    run_try(4'b0001, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    run_try(4'b0100, 4'hF, 1'b0, 2'd0, 2, 0, 1'b0, 2, 0, 1);
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    // watchdog expiry and completion tie
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 1, 10, 1);
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 10, 10);

    // ack in progress holds the scheduler in IDLE
    queue_req = 4'hF; slice_en = 4'hF; ack_tx_flag = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ack_hold_state", 32'(sched_state), 0);
    end
    queue_req = '0; ack_tx_flag = 1'b0;
    @(negedge clk);
    // request withdrawn during SELECT gives no grant
    queue_req = 4'hF;
    @(negedge clk);
    chk("drop_sel_state", 32'(sched_state), 1);
    queue_req = '0;
    @(negedge clk);
    chk("drop_state", 32'(sched_state), 0);
    chk("drop_bstart", 32'(backoff_start), 0);
    chk("drop_valid", 32'(tx_queue_idx_valid), 0);

    // asynchronous reset in the middle of TX_WAIT
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 3, 0, 4);
    run_try(4'hF, 4'hF, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rq;
      logic [3:0] sl;
      int md;
      int tm;
      int kk;
      do begin
        rq = 4'($urandom);
        sl = 4'($urandom);
      end while ((rq & sl) == 4'b0000);
      md = $urandom_range(0, 2);
      tm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      if (md == 1 && tm == 0) tm = $urandom_range(1, 15);
      kk = $urandom_range(1, (tm == 0) ? 20 : tm);
      run_try(rq, sl, 1'($urandom), 2'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0,
              1'($urandom), md, tm, kk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpu_tx_queue_sched.md
Name: xpu_tx_queue_sched

Overview:
- Selects which of the four TX queues gets the next channel-access attempt.
- Sequences the attempt: backoff request, wait for backoff/idle channel, phy_tx_start pulse, wait for try completion.
- Sits between the per-queue frame-pending/slice logic and the backoff and tx_control engines inside xpu.
- Drives tx_queue_idx to the TX datapath.

Parameters:
- NUM_QUEUE, 4, number of TX queues; fixed at 4, index width 2.
- TIMER_WIDTH, 16, width of the TX-wait watchdog counter and of timeout_top.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- queue_req  in  4  level; bit q = queue q has a frame pending
- slice_en  in  4  level; bit q = queue q allowed in the current time slice
- high_trigger  in  1  level; high-priority frame pending on hp_queue_idx
- hp_queue_idx  in  2  queue served with priority when high_trigger=1
- ack_tx_flag  in  1  level; ACK transmission in progress, defers scheduling
- ch_idle_final  in  1  level; channel idle after NAV/CCA
- backoff_done  in  1  pulse from backoff engine
- tx_try_complete  in  1  pulse; current TX try finished (ACK received or failed)
- timeout_top  in  TIMER_WIDTH  TX_WAIT watchdog limit in cycles; 0 disables it
- backoff_start  out  1  one-cycle pulse requesting a new backoff
- phy_tx_start  out  1  one-cycle pulse starting the PHY TX
- tx_queue_idx  out  2  granted queue
- tx_queue_idx_valid  out  1  grant held
- timeout_err  out  1  one-cycle pulse on watchdog expiry
- sched_state  out  3  current state encoding, for debug/AXI readback

Behaviour:
Reset:
- All outputs 0; state IDLE (encoding 0); watchdog = 0.
- last_grant = 3, so the first round-robin grant goes to queue 0.
- Reset is asynchronous and takes effect mid-operation: any in-flight grant is dropped with no pulse emitted.

Definitions:
- eligible = queue_req & slice_en.

States and transitions (encodings 0–5):
- IDLE(0): if eligible != 0 and ack_tx_flag = 0, go to SELECT.
- SELECT(1), one cycle: choose q.
  - If high_trigger = 1 and eligible[hp_queue_idx] = 1, q = hp_queue_idx.
  - Otherwise q = first eligible index searching last_grant+1, +2, +3, +4 (mod 4).
  - If eligible became 0, go back to IDLE with no grant.
  - Otherwise register tx_queue_idx = q and tx_queue_idx_valid = 1, then go to BACKOFF.
  - backoff_start = 1 for exactly the first BACKOFF cycle.
- BACKOFF(2):
  - Advance to TX_START in the cycle where backoff_done = 1, ch_idle_final = 1 and ack_tx_flag = 0 all hold.
  - A backoff_done arriving while ch_idle_final = 0 or ack_tx_flag = 1 is held (sticky) until both conditions allow; the flag clears on leaving BACKOFF.
  - If slice_en[tx_queue_idx] falls: abort to IDLE, valid goes to 0, last_grant is unchanged, no phy_tx_start.
  - Abort takes priority over a same-cycle backoff_done.
- TX_START(3), one cycle: phy_tx_start = 1 registered on this cycle; clear watchdog; go to TX_WAIT.
- TX_WAIT(4):
  - Watchdog increments every cycle.
  - On tx_try_complete, go to COMPLETE.
  - Else if timeout_top != 0 and watchdog + 1 == timeout_top: timeout_err pulse, go to COMPLETE.
  - tx_try_complete wins over a same-cycle expiry; timeout_err stays 0.
  - slice_en changes are ignored here.
- COMPLETE(5), one cycle: last_grant = tx_queue_idx; valid goes to 0; go to IDLE. tx_queue_idx keeps its last value.

Pulse rules:
- tx_try_complete / backoff_done outside their waiting state are ignored; backoff_done is not stored outside BACKOFF.
- Minimum latency from eligible rising (in IDLE) to backoff_start: 2 cycles.
- Minimum latency from backoff_done to phy_tx_start: 1 cycle.

Test Plan:
- Reset release, queue_req = 4'b0110, slice_en = 4'hF, no high_trigger:
  - Grant q1, backoff_start 2 cycles after request.
  - backoff_done + ch_idle_final → phy_tx_start one cycle later.
  - tx_try_complete → valid low; next grant q2.
- Round-robin: all four queues requesting, 8 consecutive completed tries → grant order 0,1,2,3,0,1,2,3.
- Priority: last_grant = 0, queue_req = 4'hF, high_trigger = 1, hp_queue_idx = 3 → grant q3, not q1.
- Deferral: backoff_done while ch_idle_final = 0 → no phy_tx_start; ch_idle_final rises 5 cycles later → phy_tx_start the next cycle.
- Slice abort: grant q2 in BACKOFF, slice_en[2] drops → return to IDLE, no phy_tx_start, next grant again starts search at q1.
- Watchdog:
  - timeout_top = 10, no tx_try_complete → timeout_err exactly 10 cycles after phy_tx_start cycle, then IDLE.
  - Repeat with tx_try_complete on the 10th cycle → no timeout_err.
  - Assert s00_axi_aresetn low mid-TX_WAIT → all outputs 0 immediately.
